// File: rtl/pipeline_int_ctrl.sv
// pipeline_int_ctrl
// Interrupt sequencer for the 5-stage pipeline. Latches requests, waits for a
// real instruction in ID with no hazards, stalls IF/ID while older work drains,
// then flushes IF/ID and redirects the PC to the handler vector. On eret it
// flushes again and redirects back to the saved EPC.
module pipeline_int_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  int_req,
    input  logic [3:0]  int_mask,
    input  logic        jp_success,
    input  logic        load_use,
    input  logic        eret_id,
    input  logic [31:0] pc_4_if_id,
    output logic        int_nop,
    output logic        inting,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic [31:0] epc,
    output logic [1:0]  int_cause,
    output logic        in_handler
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ENTER,
        S_HANDLER,
        S_RETURN
    } state_t;

    // Counter preload: the DRAIN state lasts exactly DRAIN_CYCLES cycles.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_pend;
    logic [3:0]  r_cnt;
    logic [31:0] r_epc;
    logic [1:0]  r_cause;
    logic [3:0]  w_eligible;
    logic [1:0]  w_winner;
    logic        w_start;
    logic [3:0]  w_clr;

    // Mask only matters while idle: it is consumed solely through w_start.
    assign w_eligible = r_pend & int_mask;

    // Priority pick: lowest eligible index wins (loop runs high to low so the
    // last hit is the lowest index).
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_eligible[i]) w_winner = 2'(i);
        end
    end

    // Entry needs a real instruction in ID (nonzero PC+4) and no hazard, so
    // EPC points at an instruction that has not yet executed.
    assign w_start = (r_state == S_IDLE) && (w_eligible != 4'd0) &&
                     !jp_success && !load_use && (pc_4_if_id != 32'd0);

    // Serviced bit is cleared on the ENTER cycle.
    assign w_clr = (r_state == S_ENTER) ? (4'd1 << r_cause) : 4'd0;

    // Next-state and state-decoded outputs (no input reaches an output).
    always_comb begin
        w_state_nxt   = r_state;
        int_nop       = 1'b0;
        inting        = 1'b0;
        pc_redirect   = 1'b0;
        in_handler    = 1'b0;
        redirect_addr = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                int_nop = 1'b1;
                if (r_cnt == 4'd0) w_state_nxt = S_ENTER;
            end
            S_ENTER: begin
                inting        = 1'b1;
                pc_redirect   = 1'b1;
                redirect_addr = VEC_BASE + 32'(r_cause) * VEC_STRIDE;
                w_state_nxt   = S_HANDLER;
            end
            S_HANDLER: begin
                in_handler = 1'b1;
                if (eret_id) w_state_nxt = S_RETURN;
            end
            S_RETURN: begin
                inting        = 1'b1;
                pc_redirect   = 1'b1;
                redirect_addr = r_epc;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Pending latch: a request on the same edge as the clear keeps its bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pend <= 4'd0;
        else        r_pend <= (r_pend & ~w_clr) | int_req;
    end

    // Drain counter: preload on entry, count down to zero while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_cnt <= 4'd0;
        else if (w_start)                             r_cnt <= DRAIN_LOAD;
        else if (r_state == S_DRAIN && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end

    // EPC and cause are captured once, at the IDLE->DRAIN decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc   <= 32'd0;
            r_cause <= 2'd0;
        end else if (w_start) begin
            r_epc   <= pc_4_if_id - 32'd4;
            r_cause <= w_winner;
        end
    end

    assign epc       = r_epc;
    assign int_cause = r_cause;

endmodule

// File: tb/tb_pipeline_int_ctrl.sv
// tb_pipeline_int_ctrl
// Directed scenarios with literal expectations, then randomized traffic. A
// timeline model (when did the current interrupt start, when did eret land)
// predicts every output on every cycle.
module tb_pipeline_int_ctrl;

    localparam int          D      = 3;
    localparam logic [31:0] VBASE  = 32'h0000_0800;
    localparam logic [31:0] VSTEP  = 32'h0000_0010;

    logic        clk;
    logic        rst_n;
    logic [3:0]  int_req;
    logic [3:0]  int_mask;
    logic        jp_success;
    logic        load_use;
    logic        eret_id;
    logic [31:0] pc_4_if_id;
    logic        int_nop;
    logic        inting;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic [31:0] epc;
    logic [1:0]  int_cause;
    logic        in_handler;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_int_ctrl #(
        .DRAIN_CYCLES (D),
        .VEC_BASE     (VBASE),
        .VEC_STRIDE   (VSTEP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .int_req       (int_req),
        .int_mask      (int_mask),
        .jp_success    (jp_success),
        .load_use      (load_use),
        .eret_id       (eret_id),
        .pc_4_if_id    (pc_4_if_id),
        .int_nop       (int_nop),
        .inting        (inting),
        .pc_redirect   (pc_redirect),
        .redirect_addr (redirect_addr),
        .epc           (epc),
        .int_cause     (int_cause),
        .in_handler    (in_handler)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model. An interrupt decided at edge s occupies:
    //   drain cycles s .. s+D-1, enter cycle s+D, handler from s+D+1 until
    //   the cycle before the edge r that sampled eret, return cycle r.
    // ------------------------------------------------------------------
    typedef enum {P_IDLE, P_DRAIN, P_ENTER, P_HANDLER, P_RETURN} phase_e;

    int          n      = 0;
    bit          m_active = 1'b0;
    int          m_s    = 0;
    int          m_r    = -1;
    logic [3:0]  m_pend = 4'd0;
    logic [31:0] m_epc  = 32'd0;
    logic [1:0]  m_cause = 2'd0;

    function automatic phase_e phase_at(input int c);
        if (!m_active || c < m_s)   return P_IDLE;
        if (c < m_s + D)            return P_DRAIN;
        if (c == m_s + D)           return P_ENTER;
        if (m_r < 0 || c < m_r)     return P_HANDLER;
        if (c == m_r)               return P_RETURN;
        return P_IDLE;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // Model update at each edge, then compare shortly after the edge.
    always @(posedge clk) begin : compare
        phase_e      prev;
        phase_e      cur;
        logic [3:0]  clr;
        logic [3:0]  elig;
        logic [31:0] e_addr;
        n = n + 1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_r      = -1;
            m_pend   = 4'd0;
            m_epc    = 32'd0;
            m_cause  = 2'd0;
        end else begin
            prev = phase_at(n - 1);
            clr  = 4'd0;
            if (prev == P_ENTER)              clr[m_cause] = 1'b1;
            if (prev == P_RETURN)             m_active = 1'b0;
            if (prev == P_HANDLER && eret_id) m_r = n;
            if (prev == P_IDLE) begin
                elig = m_pend & int_mask;
                if (elig != 4'd0 && !jp_success && !load_use && pc_4_if_id != 32'd0) begin
                    m_active = 1'b1;
                    m_s      = n;
                    m_r      = -1;
                    m_epc    = pc_4_if_id - 32'd4;
                    m_cause  = lowest(elig);
                end
            end
            m_pend = (m_pend & ~clr) | int_req;
        end
        cur    = phase_at(n);
        e_addr = (cur == P_ENTER)  ? VBASE + 32'(m_cause) * VSTEP :
                 (cur == P_RETURN) ? m_epc : 32'd0;
        #1;
        check("m_int_nop",     32'(int_nop),     32'(cur == P_DRAIN));
        check("m_inting",      32'(inting),      32'(cur == P_ENTER || cur == P_RETURN));
        check("m_pc_redirect", 32'(pc_redirect), 32'(cur == P_ENTER || cur == P_RETURN));
        check("m_redirect",    redirect_addr,    e_addr);
        check("m_epc",         epc,              m_epc);
        check("m_cause",       32'(int_cause),   32'(m_cause));
        check("m_in_handler",  32'(in_handler),  32'(cur == P_HANDLER));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge).
    // ------------------------------------------------------------------
    task automatic wait_handler(input int budget);
        int k = 0;
        while (!in_handler && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("reach_handler", 32'(in_handler), 32'd1);
    endtask

    task automatic do_eret();
        eret_id = 1'b1;
        @(negedge clk);
        eret_id = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        int_req    = 4'd0;
        int_mask   = 4'hF;
        jp_success = 1'b0;
        load_use   = 1'b0;
        eret_id    = 1'b0;
        pc_4_if_id = 32'h0000_0104;
        repeat (2) @(negedge clk);
        check("rst_int_nop",  32'(int_nop),    32'd0);
        check("rst_inting",   32'(inting),     32'd0);
        check("rst_redirect", redirect_addr,   32'd0);
        check("rst_epc",      epc,             32'd0);
        check("rst_cause",    32'(int_cause),  32'd0);
        check("rst_handler",  32'(in_handler), 32'd0);
        rst_n = 1'b1;

        // Single source, cause 2.
        int_req = 4'b0100;
        @(negedge clk);
        int_req = 4'd0;
        check("t1_wait", 32'(int_nop), 32'd0);
        @(negedge clk);
        check("t1_nop1",  32'(int_nop),   32'd1);
        check("t1_epc",   epc,            32'h0000_0100);
        check("t1_cause", 32'(int_cause), 32'd2);
        @(negedge clk);
        check("t1_nop2", 32'(int_nop), 32'd1);
        @(negedge clk);
        check("t1_nop3", 32'(int_nop), 32'd1);
        @(negedge clk);
        check("t1_nop_off", 32'(int_nop),     32'd0);
        check("t1_inting",  32'(inting),      32'd1);
        check("t1_pcred",   32'(pc_redirect), 32'd1);
        check("t1_vector",  redirect_addr,    32'h0000_0820);
        @(negedge clk);
        check("t1_handler", 32'(in_handler), 32'd1);
        check("t1_flush0",  32'(inting),     32'd0);

        // Return, then eret while idle.
        eret_id = 1'b1;
        @(negedge clk);
        eret_id = 1'b0;
        check("ret_inting",  32'(inting),     32'd1);
        check("ret_addr",    redirect_addr,   32'h0000_0100);
        check("ret_handler", 32'(in_handler), 32'd0);
        @(negedge clk);
        check("ret_idle", 32'(inting), 32'd0);
        eret_id = 1'b1;
        @(negedge clk);
        eret_id = 1'b0;
        check("eret_idle_inting",  32'(inting),     32'd0);
        check("eret_idle_nop",     32'(int_nop),    32'd0);
        check("eret_idle_handler", 32'(in_handler), 32'd0);

        // Priority and mask: 1011 masked by 1010 -> cause 1, then cause 3.
        int_mask = 4'b1010;
        int_req  = 4'b1011;
        @(negedge clk);
        int_req = 4'd0;
        @(negedge clk);
        check("pri_cause1", 32'(int_cause), 32'd1);
        repeat (3) @(negedge clk);
        check("pri_vec1", redirect_addr, 32'h0000_0810);
        @(negedge clk);
        do_eret();
        @(negedge clk);
        check("pri_nop3",   32'(int_nop),   32'd1);
        check("pri_cause3", 32'(int_cause), 32'd3);
        repeat (3) @(negedge clk);
        check("pri_vec3", redirect_addr, 32'h0000_0830);
        @(negedge clk);
        do_eret();
        repeat (2) @(negedge clk);
        check("pri_bit0_masked", 32'(int_nop), 32'd0);
        int_mask = 4'hF;
        @(negedge clk);
        check("pri_bit0_nop",   32'(int_nop),   32'd1);
        check("pri_bit0_cause", 32'(int_cause), 32'd0);
        wait_handler(20);
        do_eret();

        // Deferral: jump hazard, then a bubble in ID.
        @(negedge clk);
        jp_success = 1'b1;
        int_req    = 4'b0001;
        @(negedge clk);
        int_req = 4'd0;
        @(negedge clk);
        jp_success = 1'b0;
        pc_4_if_id = 32'd0;
        check("def_jump", 32'(int_nop), 32'd0);
        @(negedge clk);
        pc_4_if_id = 32'h0000_0200;
        check("def_bubble", 32'(int_nop), 32'd0);
        @(negedge clk);
        check("def_nop", 32'(int_nop), 32'd1);
        check("def_epc", epc,          32'h0000_01FC);
        pc_4_if_id = 32'h0000_0104;
        wait_handler(20);
        do_eret();

        // Request while in the handler is held until after RETURN.
        int_req = 4'b0100;
        @(negedge clk);
        int_req = 4'd0;
        wait_handler(20);
        int_req = 4'b0001;
        @(negedge clk);
        int_req = 4'd0;
        repeat (3) @(negedge clk);
        check("hreq_blocked", 32'(int_nop),    32'd0);
        check("hreq_stay",    32'(in_handler), 32'd1);
        eret_id = 1'b1;
        @(negedge clk);
        eret_id = 1'b0;
        check("hreq_ret", redirect_addr, 32'h0000_0100);
        @(negedge clk);
        check("hreq_idle", 32'(int_nop), 32'd0);
        @(negedge clk);
        check("hreq_nop",   32'(int_nop),   32'd1);
        check("hreq_cause", 32'(int_cause), 32'd0);
        wait_handler(20);
        do_eret();

        // Reset in the 2nd drain cycle.
        int_req = 4'b0001;
        @(negedge clk);
        int_req = 4'd0;
        repeat (2) @(negedge clk);
        check("rd_drain", 32'(int_nop), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rd_nop_async", 32'(int_nop),    32'd0);
        check("rd_epc_async", epc,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rd_no_entry", 32'(int_nop), 32'd0);
        check("rd_no_flush", 32'(inting),  32'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            int_req    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 15) == 0) int_mask = 4'($urandom);
            jp_success = ($urandom_range(0, 3) == 0);
            load_use   = ($urandom_range(0, 3) == 0);
            eret_id    = ($urandom_range(0, 4) == 0);
            pc_4_if_id = ($urandom_range(0, 9) == 0) ? 32'd0 : (32'($urandom) & 32'hFFFF_FFFC);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        int_req    = 4'd0;
        jp_success = 1'b0;
        load_use   = 1'b0;
        eret_id    = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
